booth_r4_mult_seq: RTL

- Parametrised, sequential radix-4 Booth multiplier built on a generalised add/subtract datapath.
- Operand width is configurable, and operands can be signed or unsigned.
- Retires one radix-4 digit (add/sub of 0, ±M, ±2M, then arithmetic shift right by 2) per clock.
- Exposes a start/busy/done handshake so the multiplier can sit behind a simple controller or register-file front end.

---
 rtl/booth_r4_mult_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/booth_r4_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// booth_r4_mult_seq : sequential radix-4 Booth multiplier, one digit per clock
// Rev 1.0
// ============================================================================
module booth_r4_mult_seq #(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     reg_M,
   input  logic [WIDTH-1:0]     reg_Q,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int EW    = SIGNED ? WIDTH : WIDTH + 2;
   localparam int AW    = EW + 2;
   localparam int STEPS = EW / 2;
   localparam int CW    = $clog2(STEPS + 1);
   localparam int SW    = AW + EW + 1;
   localparam logic [CW-1:0] C_LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      a_q, a_d;
   logic [AW-1:0]      m_q, m_d;
   logic [EW-1:0]      q_q, q_d;
   logic               qm1_q, qm1_d;
   logic [CW-1:0]      count_q, count_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [AW-1:0]      m_ext;
   logic [EW-1:0]      q_ext;
   logic [AW-1:0]      addend;
   logic               cin;
   logic [AW-1:0]      sum;
   logic [SW-1:0]      sh;

   // Unsigned operands get two zero bits so the Booth recoding sees them as positive.
   if (SIGNED) begin : g_signed_ext
      assign m_ext = {{2{reg_M[WIDTH-1]}}, reg_M};
      assign q_ext = reg_Q;
   end else begin : g_unsigned_ext
      assign m_ext = {4'b0000, reg_M};
      assign q_ext = {2'b00, reg_Q};
   end

   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case ({q_q[1:0], qm1_q})
         3'b001, 3'b010: addend = m_q;
         3'b011:         addend = {m_q[AW-2:0], 1'b0};
         3'b100: begin
            addend = ~{m_q[AW-2:0], 1'b0};
            cin    = 1'b1;
         end
         3'b101, 3'b110: begin
            addend = ~m_q;
            cin    = 1'b1;
         end
         default: begin
            addend = '0;
            cin    = 1'b0;
         end
      endcase
      sum = a_q + addend + AW'(cin);
      // Arithmetic shift of {A, Q, Q(-1)} by two; Q[0] and Q(-1) fall off the end.
      sh  = {{2{sum[AW-1]}}, sum, q_q[EW-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      m_d       = m_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      count_d   = count_q;
      product_d = product_q;
      busy_d    = (state_q == S_RUN);
      done_d    = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = '0;
               q_d     = q_ext;
               qm1_d   = 1'b0;
               m_d     = m_ext;
               count_d = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d     = sh[SW-1 -: AW];
            q_d     = sh[EW:1];
            qm1_d   = sh[0];
            count_d = count_q + CW'(1);
            if (count_q == C_LAST) begin
               product_d = sh[2*WIDTH:1];
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         m_q       <= m_d;
         q_q       <= q_d;
         qm1_q     <= qm1_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule
`default_nettype wire
